// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a registered 2-entry result buffer and valid/ready on both sides.
// The buffer holds a head (presented on y/zero) and a tail used only when FULL.
module logic_unit_pipe #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [2:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] y,
    output logic                  zero,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [data_width-1:0] head_y_q, head_y_d;
    logic [data_width-1:0] tail_y_q, tail_y_d;
    logic                  head_z_q, head_z_d;
    logic                  tail_z_q, tail_z_d;
    logic [15:0]           op_count_q, op_count_d;

    logic                  accept;
    logic                  xfer;
    logic [data_width-1:0] result;
    logic                  result_zero;

    // Handshake flags decode only the state register, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        result = '0;
        unique case (op)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: result = a ^ b;
            3'b011: result = ~(a & b);
            3'b100: result = ~(a | b);
            3'b101: result = ~(a ^ b);
            3'b110: result = ~a;
            3'b111: result = a;
            default: result = '0;
        endcase
        result_zero = (result == '0);
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        head_y_d   = head_y_q;
        head_z_d   = head_z_q;
        tail_y_d   = tail_y_q;
        tail_z_d   = tail_z_q;
        op_count_d = op_count_q + {15'd0, xfer};

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_y_d = result;
                    head_z_d = result_zero;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    head_y_d = result;
                    head_z_d = result_zero;
                end else if (accept) begin
                    tail_y_d = result;
                    tail_z_d = result_zero;
                    state_d  = FULL;
                end else if (xfer) begin
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    head_y_d = tail_y_q;
                    head_z_d = tail_z_q;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: the two buffer slots are reset too; they are tiny, and this keeps y/zero X-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            head_y_q   <= '0;
            head_z_q   <= 1'b0;
            tail_y_q   <= '0;
            tail_z_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            head_y_q   <= head_y_d;
            head_z_q   <= head_z_d;
            tail_y_q   <= tail_y_d;
            tail_z_q   <= tail_z_d;
            op_count_q <= op_count_d;
        end
    end

    // A drained head keeps its stale value, so mask it while EMPTY.
    assign y        = out_valid ? head_y_q : '0;
    assign zero     = out_valid & head_z_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a queue-based reference model is compared every cycle,
// and directed scenarios pin the model with literal expectations.
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic [15:0]  op_count;

    always #5 clk = ~clk;

    logic_unit_pipe #(.data_width(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .op_count  (op_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Reference model: a queue of at most two results plus a wrapping transfer count.
    logic [W-1:0] m_q[$];
    logic [15:0]  m_count  = '0;
    bit           check_en = 1'b0;

    always @(posedge clk) begin
        bit m_acc;
        bit m_xf;
        if (reset) begin
            m_q.delete();
            m_count  = '0;
            check_en = 1'b1;
        end else begin
            m_xf  = (m_q.size() > 0) && out_ready;
            m_acc = in_valid && (m_q.size() < 2);
            if (m_xf) begin
                void'(m_q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (m_acc) m_q.push_back(ref_op(op, a, b));
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_y;
        logic         exp_v;
        if (check_en) begin
            exp_v = (m_q.size() > 0);
            exp_y = exp_v ? m_q[0] : '0;
            check("cmp_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            check("cmp_in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() < 2)});
            check("cmp_y", {24'd0, y}, {24'd0, exp_y});
            check("cmp_zero", {31'd0, zero}, {31'd0, (exp_v && exp_y == '0)});
            check("cmp_op_count", {16'd0, op_count}, {16'd0, m_count});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [2:0] oo);
        in_valid = v;
        a        = aa;
        b        = bb;
        op       = oo;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        tick();
        reset = 1'b0;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_y", {24'd0, y}, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd0);
        check("reset_op_count", {16'd0, op_count}, 32'd0);

        // NAND of F0/CC, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 8'hF0, 8'hCC, 3'b011);
        tick();
        in_valid = 1'b0;
        check("nand_valid", {31'd0, out_valid}, 32'd1);
        check("nand_y", {24'd0, y}, 32'h3F);
        check("nand_zero", {31'd0, zero}, 32'd0);
        tick();
        check("nand_count", {16'd0, op_count}, 32'd1);

        // AND giving zero, then XOR giving all ones
        drive(1'b1, 8'h0F, 8'hF0, 3'b000);
        tick();
        check("and_y", {24'd0, y}, 32'h00);
        check("and_zero", {31'd0, zero}, 32'd1);
        drive(1'b1, 8'h0F, 8'hF0, 3'b010);
        tick();
        check("xor_y", {24'd0, y}, 32'hFF);
        check("xor_zero", {31'd0, zero}, 32'd0);
        in_valid = 1'b0;
        tick();

        // Backpressure: two accepts fill the buffer, third is held until space frees
        do_reset();
        drive(1'b1, 8'h01, 8'h00, 3'b111);
        tick();
        a = 8'h02;
        tick();
        check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        a = 8'h03;
        tick();
        tick();
        check("bp_hold_y", {24'd0, y}, 32'h01);
        out_ready = 1'b1;
        check("bp_first", {24'd0, y}, 32'h01);
        tick();
        check("bp_second", {24'd0, y}, 32'h02);
        tick();
        in_valid = 1'b0;
        check("bp_third", {24'd0, y}, 32'h03);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        check("bp_count", {16'd0, op_count}, 32'd3);

        // Sustained throughput: 20 back-to-back operations
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 3'($urandom));
            tick();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_count", {16'd0, op_count}, 32'd20);
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // Reset while FULL discards buffered results, ignoring handshakes that cycle
        out_ready = 1'b0;
        drive(1'b1, 8'hAA, 8'h55, 3'b001);
        tick();
        tick();
        check("full_before_reset", {31'd0, in_ready}, 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_full_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_full_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_full_y", {24'd0, y}, 32'd0);
        check("rst_full_count", {16'd0, op_count}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            op        = 3'($urandom);
            tick();
        end
        reset = 1'b0;

        // Transfer counter wrap
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard     = 0;
        while (m_count != 16'hFFFF && guard < 70000) begin
            a = W'($urandom);
            tick();
            guard++;
        end
        check("wrap_budget", {31'd0, (guard < 70000)}, 32'd1);
        check("wrap_ffff", {16'd0, op_count}, 32'hFFFF);
        tick();
        check("wrap_zero", {16'd0, op_count}, 32'h0000);
        in_valid = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
